// File: rtl/w5300_bus_pkg.sv
// Shared types and constants for the W5300 bus-cycle sequencer:
// FSM state encoding, default pin timing and bus widths.
package w5300_bus_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam int DEF_SETUP_CYC    = 1;
    localparam int DEF_STROBE_CYC   = 3;
    localparam int DEF_HOLD_CYC     = 1;
    localparam int DEF_RECOVERY_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } bus_state_e;

    // The timer counts down to zero, so a state lasting N cycles loads N-1.
    function automatic logic [CNT_W-1:0] reload_val(input int cyc);
        return (cyc > 0) ? CNT_W'(cyc - 1) : '0;
    endfunction

endpackage

// File: rtl/w5300_bus_seq_if.sv
// Request-side and W5300 pin-side signals of the bus sequencer.
// slave = sequencer, master = Z80-side logic plus the W5300 data pins.
interface w5300_bus_seq_if;
    import w5300_bus_pkg::*;

    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              busy;
    logic              ovr_err;
    logic [ADDR_W-1:0] w5300_addr;
    logic [DATA_W-1:0] w5300_d_out;
    logic [DATA_W-1:0] w5300_d_in;
    logic              w5300_d_oe;
    logic              w5300_cs_n;
    logic              w5300_rd_n;
    logic              w5300_wr_n;

    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, w5300_d_in,
        output rdata, done, busy, ovr_err,
        output w5300_addr, w5300_d_out, w5300_d_oe,
        output w5300_cs_n, w5300_rd_n, w5300_wr_n
    );

    modport master (
        output req_rd, req_wr, req_addr, req_wdata, w5300_d_in,
        input  rdata, done, busy, ovr_err,
        input  w5300_addr, w5300_d_out, w5300_d_oe,
        input  w5300_cs_n, w5300_rd_n, w5300_wr_n
    );

endinterface

// File: rtl/w5300_bus_timer.sv
// Loadable 4-bit down-counter with zero flag; times every FSM state.
module w5300_bus_timer
    import w5300_bus_pkg::*;
(
    input  logic             fclk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: registers use <= so every flop samples pre-edge values.
    always_ff @(posedge fclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/w5300_bus_seq.sv
// W5300 bus-cycle sequencer with one-deep pending slot.
// Optional W5300_BUSSEQ_ZWAIT_EN adds the z80_wait stall output.
module w5300_bus_seq
    import w5300_bus_pkg::*;
#(
    parameter int SETUP_CYC    = DEF_SETUP_CYC,
    parameter int STROBE_CYC   = DEF_STROBE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int RECOVERY_CYC = DEF_RECOVERY_CYC
) (
    input  logic           fclk,
    input  logic           rst,
    w5300_bus_seq_if.slave bus
`ifdef W5300_BUSSEQ_ZWAIT_EN
    ,
    output logic           z80_wait
`endif
);

    localparam bus_state_e FIRST_ST = (SETUP_CYC > 0) ? ST_SETUP : ST_STROBE;

    bus_state_e        state_q, state_d;
    logic              start_new, start_pend, access_end, leave_rec;
    logic              tmr_load, tmr_zero;
    logic [CNT_W-1:0]  tmr_val;
    logic              req_any, busy, fill, ovr_set, cs_act;
    logic              pend_valid_q, pend_wr_q;
    logic [ADDR_W-1:0] pend_addr_q, addr_q;
    logic [DATA_W-1:0] pend_wdata_q, dout_q, rdata_q;
    logic              wr_q, done_q, ovr_q;

    function automatic logic [CNT_W-1:0] state_len(input bus_state_e s);
        case (s)
            ST_SETUP:   return reload_val(SETUP_CYC);
            ST_STROBE:  return reload_val(STROBE_CYC);
            ST_HOLD:    return reload_val(HOLD_CYC);
            ST_RECOVER: return reload_val(RECOVERY_CYC);
            default:    return '0;
        endcase
    endfunction

    assign req_any = bus.req_rd | bus.req_wr;
    assign busy    = (state_q != ST_IDLE) | pend_valid_q;

    w5300_bus_timer u_timer (
        .fclk       (fclk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_new  = 1'b0;
        start_pend = 1'b0;
        access_end = 1'b0;
        leave_rec  = 1'b0;
        case (state_q)
            ST_IDLE:    if (req_any) start_new = 1'b1;
            ST_SETUP:   if (tmr_zero) state_d = ST_STROBE;
            ST_STROBE:  if (tmr_zero) begin
                            if (HOLD_CYC > 0) state_d = ST_HOLD;
                            else              access_end = 1'b1;
                        end
            ST_HOLD:    if (tmr_zero) access_end = 1'b1;
            ST_RECOVER: if (tmr_zero) leave_rec = 1'b1;
            default:    state_d = ST_IDLE;
        endcase
        if (access_end) begin
            if (RECOVERY_CYC > 0) state_d = ST_RECOVER;
            else                  leave_rec = 1'b1;
        end
        // A request arriving while the bus frees up starts directly instead of parking.
        if (leave_rec) begin
            if (pend_valid_q)  start_pend = 1'b1;
            else if (req_any)  start_new  = 1'b1;
            else               state_d    = ST_IDLE;
        end
        if (start_new || start_pend) state_d = FIRST_ST;
        tmr_load = (state_d != state_q) || start_new || start_pend;
        tmr_val  = state_len(state_d);
    end

    always_comb begin
        cs_act         = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
        bus.w5300_cs_n = !cs_act;
        bus.w5300_rd_n = !((state_q == ST_STROBE) && !wr_q);
        bus.w5300_wr_n = !((state_q == ST_STROBE) && wr_q);
        bus.w5300_d_oe = cs_act && wr_q;
    end

    assign fill    = req_any && (state_q != ST_IDLE) && !pend_valid_q && !start_new;
    assign ovr_set = (bus.req_rd && bus.req_wr) ||
                     (req_any && (state_q != ST_IDLE) && pend_valid_q);

    always_ff @(posedge fclk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            done_q <= access_end;
            if (start_new) begin
                addr_q <= bus.req_addr;
                wr_q   <= bus.req_wr;
                if (bus.req_wr) dout_q <= bus.req_wdata;
            end else if (start_pend) begin
                addr_q <= pend_addr_q;
                wr_q   <= pend_wr_q;
                if (pend_wr_q) dout_q <= pend_wdata_q;
            end
            if (start_pend) pend_valid_q <= 1'b0;
            if (fill)       pend_valid_q <= 1'b1;
            if (ovr_set)    ovr_q        <= 1'b1;
            if ((state_q == ST_STROBE) && tmr_zero && !wr_q) rdata_q <= bus.w5300_d_in;
        end
    end

    // NOTE: the pending payload has no reset; pend_valid_q qualifies it.
    always_ff @(posedge fclk) begin
        if (fill) begin
            pend_addr_q  <= bus.req_addr;
            pend_wdata_q <= bus.req_wdata;
            pend_wr_q    <= bus.req_wr;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy;
    assign bus.ovr_err     = ovr_q;
    assign bus.w5300_addr  = addr_q;
    assign bus.w5300_d_out = dout_q;

`ifdef W5300_BUSSEQ_ZWAIT_EN
    logic wait_q;

    // Held until the done of the parked request, i.e. a done with nothing left pending.
    always_ff @(posedge fclk) begin
        if (rst) begin
            wait_q <= 1'b0;
        end else if (req_any && busy) begin
            wait_q <= 1'b1;
        end else if (done_q && !pend_valid_q) begin
            wait_q <= 1'b0;
        end
    end

    assign z80_wait = wait_q | (req_any & busy);
`endif

endmodule

// File: tb/tb_w5300_bus_seq.sv
// Self-checking bench for w5300_bus_seq: per-cycle pin model plus a done/rdata scoreboard.
module tb_w5300_bus_seq;
    import w5300_bus_pkg::*;

    localparam int S   = DEF_SETUP_CYC;
    localparam int ST  = DEF_STROBE_CYC;
    localparam int H   = DEF_HOLD_CYC;
    localparam int R   = DEF_RECOVERY_CYC;
    localparam int ACC = S + ST + H;
    localparam int PER = ACC + R;

    typedef struct { int cyc; bit is_rd; logic [7:0] rd; } exp_t;
    typedef struct { int r; int s; bit wr; logic [9:0] a; logic [7:0] d; } acc_t;

    logic fclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    acc_t stim_q[$];

    w5300_bus_seq_if bus ();
    w5300_bus_seq_if bus_z ();

`ifdef W5300_BUSSEQ_ZWAIT_EN
    logic zw, zw_z;
`endif

    w5300_bus_seq dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus)
`ifdef W5300_BUSSEQ_ZWAIT_EN
        , .z80_wait (zw)
`endif
    );

    w5300_bus_seq #(
        .SETUP_CYC    (0),
        .STROBE_CYC   (1),
        .HOLD_CYC     (0),
        .RECOVERY_CYC (0)
    ) dut_z (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus_z)
`ifdef W5300_BUSSEQ_ZWAIT_EN
        , .z80_wait (zw_z)
`endif
    );

    always #5 fclk = ~fclk;
    always @(posedge fclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge fclk) begin : mon
        exp_t e;
        if (!rst && bus.done) begin
            check("sb_has_entry", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("done_cyc", cyc, e.cyc);
                if (e.is_rd) check("rdata", 32'(bus.rdata), 32'(e.rd));
            end
        end
    end

    task automatic add_req(input int r, input bit wr, input logic [9:0] a, input logic [7:0] d);
        acc_t x;
        x.r = r; x.s = 0; x.wr = wr; x.a = a; x.d = d;
        stim_q.push_back(x);
    endtask

    // Requests at relative cycles; reads carry the value the pins return.
    task automatic run_seq(input int n);
        acc_t sched[$];
        int   drops[$];
        int   s_last;
        int   base;
        acc_t a;
        exp_t e;
        s_last = -1000;
        foreach (stim_q[i]) begin
            a = stim_q[i];
            if (s_last > a.r) begin
                drops.push_back(a.r);
            end else begin
                a.s    = (a.r <= s_last + PER - 1) ? s_last + PER : a.r + 1;
                s_last = a.s;
                sched.push_back(a);
            end
        end
        base = cyc;
        foreach (sched[i]) begin
            e.cyc = base + sched[i].s + ACC; e.is_rd = !sched[i].wr; e.rd = sched[i].d;
            exp_q.push_back(e);
        end
        for (int t = 0; t < n; t++) begin
            logic ecs, erd, ewr, eoe, ebusy, eovr;
            logic [9:0] ea;
            logic [7:0] ed;
            ecs = 0; erd = 0; ewr = 0; eoe = 0; ebusy = 0; eovr = 0; ea = '0; ed = '0;
            bus.req_rd = 1'b0; bus.req_wr = 1'b0; bus.w5300_d_in = 8'h00;
            foreach (stim_q[i]) if (stim_q[i].r == t) begin
                bus.req_wr = stim_q[i].wr; bus.req_rd = !stim_q[i].wr;
                bus.req_addr = stim_q[i].a; bus.req_wdata = stim_q[i].d;
            end
            foreach (sched[i]) begin
                if (t >= sched[i].s && t < sched[i].s + ACC) begin
                    ecs = 1; ea = sched[i].a;
                    if (sched[i].wr) begin eoe = 1; ed = sched[i].d; end
                end
                if (t >= sched[i].s + S && t < sched[i].s + S + ST) begin
                    if (sched[i].wr) ewr = 1;
                    else begin erd = 1; bus.w5300_d_in = sched[i].d; end
                end
                if (t > sched[i].r && t < sched[i].s + PER) ebusy = 1;
            end
            foreach (drops[i]) if (t > drops[i]) eovr = 1;
            @(negedge fclk);
            check("cs_n", 32'(bus.w5300_cs_n), 32'(!ecs));
            check("rd_n", 32'(bus.w5300_rd_n), 32'(!erd));
            check("wr_n", 32'(bus.w5300_wr_n), 32'(!ewr));
            check("d_oe", 32'(bus.w5300_d_oe), 32'(eoe));
            check("busy", 32'(bus.busy), 32'(ebusy));
            check("ovr_err", 32'(bus.ovr_err), 32'(eovr));
            if (ecs) check("addr", 32'(bus.w5300_addr), 32'(ea));
            if (eoe) check("d_out", 32'(bus.w5300_d_out), 32'(ed));
            @(posedge fclk); #1;
        end
        bus.req_rd = 1'b0; bus.req_wr = 1'b0; bus.w5300_d_in = 8'h00;
        check("sb_drain", exp_q.size(), 0);
        stim_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_rd = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.w5300_d_in = '0;
        bus_z.req_rd = 0; bus_z.req_wr = 0; bus_z.req_addr = '0; bus_z.req_wdata = '0; bus_z.w5300_d_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge fclk);
        @(negedge fclk);
        check("rst_cs_n", 32'(bus.w5300_cs_n), 1);
        check("rst_rd_n", 32'(bus.w5300_rd_n), 1);
        check("rst_wr_n", 32'(bus.w5300_wr_n), 1);
        check("rst_d_oe", 32'(bus.w5300_d_oe), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ovr", 32'(bus.ovr_err), 0);
        check("rst_rdata", 32'(bus.rdata), 0);
        check("rst_addr", 32'(bus.w5300_addr), 0);
        check("rst_d_out", 32'(bus.w5300_d_out), 0);
        check("rst_z_cs_n", 32'(bus_z.w5300_cs_n), 1);
        @(posedge fclk); #1;
        rst = 1'b0;

        // Write, then a read starting as soon as the bus is idle again.
        add_req(0, 1, 10'h2A5, 8'h5C);
        run_seq(PER + 1);
        add_req(0, 0, 10'h3F0, 8'hA7);
        run_seq(PER + 2);

        // Back-to-back: second request parks and starts when recovery ends.
        add_req(0, 1, 10'h155, 8'hC3);
        add_req(2, 0, 10'h0AA, 8'h96);
        run_seq(2 * PER + 2);

        // Overrun: third request finds the slot full.
        add_req(0, 1, 10'h001, 8'h11);
        add_req(1, 0, 10'h002, 8'h22);
        add_req(2, 1, 10'h003, 8'h33);
        run_seq(2 * PER + 2);

        rst = 1'b1;
        @(posedge fclk); #1;
        rst = 1'b0;
        @(negedge fclk);
        check("ovr_cleared", 32'(bus.ovr_err), 0);
        @(posedge fclk); #1;

        // Reset during the strobe of a write with a read pending.
        bus.req_wr = 1; bus.req_addr = 10'h321; bus.req_wdata = 8'h77;
        @(posedge fclk); #1;
        bus.req_wr = 0; bus.req_rd = 1; bus.req_addr = 10'h123;
        @(posedge fclk); #1;
        bus.req_rd = 0;
        @(negedge fclk);
        check("mid_busy", 32'(bus.busy), 1);
        check("mid_cs_n", 32'(bus.w5300_cs_n), 0);
        @(posedge fclk); #1;
        rst = 1'b1;
        @(negedge fclk);
        check("mid_wr_n", 32'(bus.w5300_wr_n), 0);
        @(posedge fclk); #1;
        rst = 1'b0;
        @(negedge fclk);
        check("post_cs_n", 32'(bus.w5300_cs_n), 1);
        check("post_wr_n", 32'(bus.w5300_wr_n), 1);
        check("post_d_oe", 32'(bus.w5300_d_oe), 0);
        check("post_busy", 32'(bus.busy), 0);
        check("post_ovr", 32'(bus.ovr_err), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge fclk);
            check("post_idle_cs_n", 32'(bus.w5300_cs_n), 1);
            check("post_no_done", 32'(bus.done), 0);
        end
        @(posedge fclk); #1;

        // All-minimum timing on the second instance.
        bus_z.req_rd = 1; bus_z.req_addr = 10'h0F0;
        @(posedge fclk); #1;
        bus_z.req_rd = 0; bus_z.w5300_d_in = 8'h3C;
        @(negedge fclk);
        check("z_cs_n_c1", 32'(bus_z.w5300_cs_n), 0);
        check("z_rd_n_c1", 32'(bus_z.w5300_rd_n), 0);
        check("z_done_c1", 32'(bus_z.done), 0);
        check("z_addr_c1", 32'(bus_z.w5300_addr), 32'h0F0);
        @(posedge fclk); #1;
        bus_z.w5300_d_in = 8'h00;
        @(negedge fclk);
        check("z_cs_n_c2", 32'(bus_z.w5300_cs_n), 1);
        check("z_rd_n_c2", 32'(bus_z.w5300_rd_n), 1);
        check("z_done_c2", 32'(bus_z.done), 1);
        check("z_rdata", 32'(bus_z.rdata), 32'h3C);
        @(posedge fclk); #1;
        @(negedge fclk);
        check("z_done_c3", 32'(bus_z.done), 0);
        check("z_busy_c3", 32'(bus_z.busy), 0);

        check("sb_final", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
